// File: rtl/ce_ls_frame_rx.sv
// ----------------------------------------------------------------------------
// ce_ls_frame_rx
//
// Receiving end of the channel-estimation LS sample stream. Incoming beats
// are checked against the frame length N (fftpts) latched on the sop beat,
// tagged with a frame status, buffered in a first-word-fall-through FIFO and
// re-emitted to the downstream CE stage. Saturating good/bad frame counters
// are kept for status readout.
//
// Ports:
//   clk, rst_n            single clock, asynchronous active-low reset
//   sink_valid/ready      input handshake (sink_ready is registered)
//   sink_error            upstream error tag, ORed across the frame
//   sink_sop/eop          input frame delimiters
//   sink_real/imag        input sample, two's complement
//   fftpts_in             frame length N, sampled on the sop beat
//   source_valid/ready    output handshake (FWFT: valid = FIFO not empty)
//   source_error          frame status, meaningful on the eop beat only
//                         00 ok, 01 short/degenerate, 10 long, 11 aborted or
//                         upstream error
//   source_sop/eop        output frame delimiters
//   source_real/imag      output sample
//   fftpts_out            N of the frame currently on the output
//   frames_ok/frames_err  saturating frame counters
// ----------------------------------------------------------------------------
module ce_ls_frame_rx #(
  parameter int wData = 16,
  parameter int wPts  = 12,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sink_valid,
  output logic             sink_ready,
  input  logic [1:0]       sink_error,
  input  logic             sink_sop,
  input  logic             sink_eop,
  input  logic [wData-1:0] sink_real,
  input  logic [wData-1:0] sink_imag,
  input  logic [wPts-1:0]  fftpts_in,
  output logic             source_valid,
  input  logic             source_ready,
  output logic [1:0]       source_error,
  output logic             source_sop,
  output logic             source_eop,
  output logic [wData-1:0] source_real,
  output logic [wData-1:0] source_imag,
  output logic [wPts-1:0]  fftpts_out,
  output logic [15:0]      frames_ok,
  output logic [15:0]      frames_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = 2 + 1 + 1 + wPts + 2 * wData;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_IN_FRAME = 2'd1;
  localparam logic [1:0] ST_DROP     = 2'd2;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_LONG  = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  // Highest fill level after push/pop at which another beat may still be
  // accepted next cycle without overflowing.
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]      state_q, state_d;
  logic [wPts-1:0] n_q, n_d;
  logic [wPts-1:0] cnt_q, cnt_d;
  logic            sticky_q, sticky_d;
  logic [15:0]     ok_q, ok_d;
  logic [15:0]     bad_q, bad_d;
  logic            ready_q, ready_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [WW-1:0]   head_q, head_d;
  logic [WW-1:0]   mem_q [DEPTH];

  logic            accept_s;
  logic            push_s;
  logic            pop_s;
  logic            mem_wr_s;
  logic [1:0]      w_err_s;
  logic            w_sop_s;
  logic            w_eop_s;
  logic [wPts-1:0] w_n_s;
  logic [WW-1:0]   w_word_s;
  logic            inc_ok_s;
  logic            inc_bad_s;
  logic            err_now_s;
  logic [wPts:0]   cnt_next_s;
  logic [wPts:0]   n_ext_s;

  assign accept_s   = sink_valid & ready_q;
  assign pop_s      = (count_q != CNT_ZERO) & source_ready;
  assign err_now_s  = sticky_q | (sink_error != 2'b00);
  assign cnt_next_s = {1'b0, cnt_q} + (wPts + 1)'(1);
  assign n_ext_s    = {1'b0, n_q};
  assign w_word_s   = {w_err_s, w_sop_s, w_eop_s, w_n_s, sink_real, sink_imag};

  // Frame-checking FSM: decides per accepted beat whether to push and with
  // which tag, and which counter to bump.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    push_s    = 1'b0;
    w_err_s   = ERR_NONE;
    w_sop_s   = 1'b0;
    w_eop_s   = 1'b0;
    w_n_s     = n_q;
    inc_ok_s  = 1'b0;
    inc_bad_s = 1'b0;
    if (accept_s) begin
      case (state_q)
        ST_IDLE: begin
          if (sink_sop) begin
            push_s  = 1'b1;
            w_sop_s = 1'b1;
            w_n_s   = fftpts_in;
            // A single-beat frame or a length below 2 can never be valid.
            if (sink_eop || (fftpts_in < wPts'(2))) begin
              w_eop_s   = 1'b1;
              w_err_s   = ERR_SHORT;
              inc_bad_s = 1'b1;
            end else begin
              n_d      = fftpts_in;
              cnt_d    = wPts'(1);
              sticky_d = (sink_error != 2'b00);
              state_d  = ST_IN_FRAME;
            end
          end else begin
            inc_bad_s = 1'b1;
          end
        end
        ST_IN_FRAME: begin
          push_s = 1'b1;
          if (sink_sop) begin
            // New sop abandons the running frame; this beat closes it.
            w_eop_s   = 1'b1;
            w_err_s   = ERR_ABORT;
            inc_bad_s = 1'b1;
            sticky_d  = 1'b0;
            state_d   = ST_IDLE;
          end else if ((cnt_next_s == n_ext_s) && sink_eop) begin
            w_eop_s  = 1'b1;
            sticky_d = 1'b0;
            state_d  = ST_IDLE;
            if (err_now_s) begin
              w_err_s   = ERR_ABORT;
              inc_bad_s = 1'b1;
            end else begin
              w_err_s  = ERR_NONE;
              inc_ok_s = 1'b1;
            end
          end else if (cnt_next_s == n_ext_s) begin
            // Frame overruns N: close it here and swallow the tail.
            w_eop_s   = 1'b1;
            w_err_s   = ERR_LONG;
            inc_bad_s = 1'b1;
            sticky_d  = 1'b0;
            state_d   = ST_DROP;
          end else if (sink_eop) begin
            w_eop_s   = 1'b1;
            w_err_s   = ERR_SHORT;
            inc_bad_s = 1'b1;
            sticky_d  = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            cnt_d    = cnt_next_s[wPts-1:0];
            sticky_d = err_now_s;
          end
        end
        ST_DROP: begin
          if (sink_eop || sink_sop) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DROP;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Saturating frame counters.
  always_comb begin
    ok_d  = ok_q;
    bad_d = bad_q;
    if (inc_ok_s && (ok_q != 16'hFFFF)) begin
      ok_d = ok_q + 16'd1;
    end else begin
      ok_d = ok_q;
    end
    if (inc_bad_s && (bad_q != 16'hFFFF)) begin
      bad_d = bad_q + 16'd1;
    end else begin
      bad_d = bad_q;
    end
  end

  // FIFO bookkeeping. The head entry lives in head_q (which drives the
  // outputs directly); mem_q holds the entries queued behind it.
  always_comb begin
    count_d  = count_q;
    head_d   = head_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_wr_s = 1'b0;
    case ({push_s, pop_s})
      2'b10: begin
        count_d = count_q + CNT_ONE;
        if (count_q == CNT_ZERO) begin
          head_d = w_word_s;
        end else begin
          mem_wr_s = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
        end
      end
      2'b01: begin
        count_d = count_q - CNT_ONE;
        if (count_q > CNT_ONE) begin
          head_d   = mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
          // Outputs return to zero when the FIFO runs empty.
          head_d = '0;
        end
      end
      2'b11: begin
        count_d = count_q;
        if (count_q == CNT_ONE) begin
          head_d = w_word_s;
        end else begin
          head_d   = mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + AW'(1);
          mem_wr_s = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Ready looks at the fill level after this cycle's push/pop.
  always_comb begin
    if (count_d <= READY_MAX) begin
      ready_d = 1'b1;
    end else begin
      ready_d = 1'b0;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      ok_q     <= 16'h0000;
      bad_q    <= 16'h0000;
      ready_q  <= 1'b0;
      count_q  <= CNT_ZERO;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      ok_q     <= ok_d;
      bad_q    <= bad_d;
      ready_q  <= ready_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      head_q   <= head_d;
    end
  end

  // FIFO storage behind the head; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      mem_q[wr_ptr_q] <= w_word_s;
    end
  end

  assign sink_ready   = ready_q;
  assign source_valid = (count_q != CNT_ZERO);
  assign {source_error, source_sop, source_eop, fftpts_out, source_real, source_imag} = head_q;
  assign frames_ok    = ok_q;
  assign frames_err   = bad_q;

endmodule

// File: tb/tb_ce_ls_frame_rx.sv
module tb_ce_ls_frame_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sink_valid, sink_ready, sink_sop, sink_eop;
  logic [1:0]  sink_error;
  logic [15:0] sink_real, sink_imag;
  logic [11:0] fftpts_in;
  logic        source_valid, source_ready, source_sop, source_eop;
  logic [1:0]  source_error;
  logic [15:0] source_real, source_imag;
  logic [11:0] fftpts_out;
  logic [15:0] frames_ok, frames_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int exp_ok  = 0;
  int exp_err = 0;
  logic [47:0] cap_q[$];
  logic [47:0] exp_q[$];

  ce_ls_frame_rx #(.wData(16), .wPts(12), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_error(sink_error),
    .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag), .fftpts_in(fftpts_in),
    .source_valid(source_valid), .source_ready(source_ready),
    .source_error(source_error), .source_sop(source_sop), .source_eop(source_eop),
    .source_real(source_real), .source_imag(source_imag), .fftpts_out(fftpts_out),
    .frames_ok(frames_ok), .frames_err(frames_err)
  );

  always #5 clk = ~clk;

  // Record every beat that the next rising edge will pop.
  always @(negedge clk) begin
    if (rst_n && source_valid && source_ready) begin
      cap_q.push_back({source_error, source_sop, source_eop, fftpts_out, source_real, source_imag});
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [47:0] mkw(input logic [1:0] e, input logic s, input logic eo,
                                      input logic [11:0] n, input logic [15:0] re);
    return {e, s, eo, n, re, ~re};
  endfunction

  // Present one beat and hold it until accepted (bounded); returns at edge+1.
  task automatic send(input logic sop, input logic eop, input logic [11:0] n,
                      input logic [15:0] re, input logic [1:0] er);
    int t;
    t = 0;
    sink_valid = 1'b1; sink_sop = sop; sink_eop = eop; fftpts_in = n;
    sink_real = re; sink_imag = ~re; sink_error = er;
    while (!sink_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) check("send_timeout", 64'(t), 64'(0));
    @(posedge clk); #1;
    n_acc++;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_error = 2'b00;
  endtask

  task automatic good_frame(input logic [11:0] n, input logic [15:0] base);
    for (int i = 0; i < int'(n); i++) begin
      send(i == 0, i == int'(n) - 1, n, base + 16'(i), 2'b00);
      exp_q.push_back(mkw(2'b00, i == 0, i == int'(n) - 1, n, base + 16'(i)));
    end
    exp_ok++;
  endtask

  // Wait for the expected beats to emerge, then compare stream and counters.
  task automatic drain(input string tag);
    int t;
    t = 0;
    while (cap_q.size() < exp_q.size() && t < 300) begin
      @(posedge clk); #1; t++;
    end
    repeat (3) begin @(posedge clk); #1; end
    check({tag, "_nbeats"}, 64'(cap_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 64'(cap_q[i]), 64'(exp_q[i]));
    check({tag, "_frames_ok"}, 64'(frames_ok), 64'(exp_ok));
    check({tag, "_frames_err"}, 64'(frames_err), 64'(exp_err));
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    sink_error = 2'b00; sink_real = 16'h0000; sink_imag = 16'h0000;
    fftpts_in = 12'd0; source_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sink_ready", 64'(sink_ready), 64'(0));
    check("rst_source_valid", 64'(source_valid), 64'(0));
    check("rst_outputs", 64'({source_error, source_sop, source_eop, fftpts_out, source_real, source_imag}), 64'(0));
    check("rst_counters", 64'({frames_ok, frames_err}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_sink_ready", 64'(sink_ready), 64'(1));

    // Three back-to-back N=12 frames with 1-cycle latency.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 12; i++) begin
        send(i == 0, i == 11, 12'd12, 16'h0100 * 16'(f) + 16'(i), 2'b00);
        exp_q.push_back(mkw(2'b00, i == 0, i == 11, 12'd12, 16'h0100 * 16'(f) + 16'(i)));
        if (f == 0 && i == 0) begin
          check("lat_valid", 64'(source_valid), 64'(1));
          check("lat_sop", 64'(source_sop), 64'(1));
          check("lat_fftpts", 64'(fftpts_out), 64'(12));
        end
      end
    end
    exp_ok += 3;
    drain("b2b");

    // Back-pressure: output stalled 40 cycles, 15 beats fit before ready drops.
    source_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        good_frame(12'd12, 16'h1000);
        good_frame(12'd12, 16'h2000);
      end
      begin
        repeat (40) @(posedge clk);
        #2;
        check("stall_accepted", 64'(n_acc), 64'(15));
        check("stall_ready", 64'(sink_ready), 64'(0));
        check("stall_hold_sop", 64'({source_valid, source_sop, source_real}), 64'({1'b1, 1'b1, 16'h1000}));
        source_ready = 1'b1;
      end
    join
    drain("stall");

    // Short frame (eop on beat 5 of 8), then a good frame.
    for (int i = 0; i < 5; i++) begin
      send(i == 0, i == 4, 12'd8, 16'h3000 + 16'(i), 2'b00);
      exp_q.push_back(mkw((i == 4) ? 2'b01 : 2'b00, i == 0, i == 4, 12'd8, 16'h3000 + 16'(i)));
    end
    exp_err++;
    good_frame(12'd8, 16'h3100);
    drain("short");

    // Long frame: 12 beats without eop then eop; eop forced on beat 8.
    for (int i = 0; i < 13; i++) begin
      send(i == 0, i == 12, 12'd8, 16'h4000 + 16'(i), 2'b00);
      if (i < 8) exp_q.push_back(mkw((i == 7) ? 2'b10 : 2'b00, i == 0, i == 7, 12'd8, 16'h4000 + 16'(i)));
    end
    exp_err++;
    good_frame(12'd8, 16'h4100);
    drain("long");

    // Orphan beats, then an N=16 frame interrupted by sop on beat 6.
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 12'd16, 16'h5000 + 16'(i), 2'b00);
    exp_err += 3;
    for (int i = 0; i < 6; i++) begin
      send(i == 0 || i == 5, 1'b0, 12'd16, 16'h5100 + 16'(i), 2'b00);
      exp_q.push_back(mkw((i == 5) ? 2'b11 : 2'b00, i == 0, i == 5, 12'd16, 16'h5100 + 16'(i)));
    end
    exp_err++;
    for (int i = 0; i < 2; i++) send(1'b0, 1'b0, 12'd16, 16'h5200 + 16'(i), 2'b00);
    exp_err += 2;
    // Single-beat sop&eop frame.
    send(1'b1, 1'b1, 12'd5, 16'h5300, 2'b00);
    exp_q.push_back(mkw(2'b01, 1'b1, 1'b1, 12'd5, 16'h5300));
    exp_err++;
    // Degenerate N=1 on a sop-only beat.
    send(1'b1, 1'b0, 12'd1, 16'h5400, 2'b00);
    exp_q.push_back(mkw(2'b01, 1'b1, 1'b1, 12'd1, 16'h5400));
    exp_err++;
    // Upstream error mid-frame makes the complete frame report 11.
    for (int i = 0; i < 4; i++) begin
      send(i == 0, i == 3, 12'd4, 16'h5500 + 16'(i), (i == 1) ? 2'b10 : 2'b00);
      exp_q.push_back(mkw((i == 3) ? 2'b11 : 2'b00, i == 0, i == 3, 12'd4, 16'h5500 + 16'(i)));
    end
    exp_err++;
    // Sticky flag must not leak into the next frame.
    good_frame(12'd4, 16'h5600);
    drain("misc");

    // Asynchronous reset with 7 entries held.
    source_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(i == 0, 1'b0, 12'd12, 16'h6000 + 16'(i), 2'b00);
    check("pre_rst_valid", 64'(source_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(source_valid), 64'(0));
    check("async_rst_outputs", 64'({source_error, source_sop, source_eop, fftpts_out, source_real, source_imag}), 64'(0));
    check("async_rst_counters", 64'({frames_ok, frames_err}), 64'(0));
    check("async_rst_ready", 64'(sink_ready), 64'(0));
    cap_q.delete(); exp_q.delete();
    exp_ok = 0; exp_err = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rel_ready_low", 64'(sink_ready), 64'(0));
    @(posedge clk); #1;
    check("post_rel_ready_high", 64'(sink_ready), 64'(1));
    source_ready = 1'b1;
    good_frame(12'd4, 16'h7000);
    drain("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
